// File: rtl/parity_pkg.sv
// Shared definitions for the parity_stream slice: lane-count derivation,
// error-counter width and the per-lane parity function.
package parity_pkg;

  localparam int ERR_CNT_W  = 16;
  localparam int MAX_LANE_W = 256;

  // Default geometry; instances derive their own lane count with calc_nl().
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LANE_W = 8;
  localparam int DEF_NL     = DEF_DATA_W / DEF_LANE_W;

  function automatic int calc_nl(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  // Bits at or above lane_w are ignored, so callers zero-extend narrower lanes.
  function automatic logic lane_parity(input logic [MAX_LANE_W-1:0] data,
                                       input int                    lane_w,
                                       input bit                    odd);
    logic p;
    p = odd;
    for (int i = 0; i < MAX_LANE_W; i++) begin
      if (i < lane_w) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/parity_lane_xor.sv
// Combinational parity of one LANE_W-bit lane; ODD != 0 inverts the result.
module parity_lane_xor
  import parity_pkg::*;
#(
  parameter int LANE_W = 8,
  parameter int ODD    = 0
) (
  input  logic [LANE_W-1:0] i_lane,
  output logic              o_par
);

  logic [MAX_LANE_W-1:0] w_lane_ext;

  assign w_lane_ext = MAX_LANE_W'(i_lane);
  assign o_par      = lane_parity(w_lane_ext, LANE_W, ODD != 0);

endmodule

// File: rtl/parity_stream.sv
// Streaming lane/packet parity generator-checker with one registered output stage.
// Optional error counter port err_cnt is enabled by defining PARITY_STREAM_ERR_CNT_EN.
module parity_stream
  import parity_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int LANE_W = 8,
  parameter  int ODD    = 0,
  localparam int NL     = calc_nl(DATA_W, LANE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_chk,
  input  logic [NL-1:0]     in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [NL-1:0]     out_lane_par,
  output logic              out_pkt_par,
  output logic              out_err,
  output logic              err_sticky,
  input  logic              err_clr
`ifdef PARITY_STREAM_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  logic              w_accept;
  logic              w_odd;
  logic [NL-1:0]     w_lane_par;
  logic              w_pkt_par;
  logic              w_err;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [NL-1:0]     r_out_lane_par;
  logic              r_out_pkt_par;
  logic              r_out_err;
  logic              r_err_sticky;
  logic              r_acc;
  logic              r_first;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    parity_lane_xor #(
      .LANE_W (LANE_W),
      .ODD    (ODD)
    ) u_lane (
      .i_lane (in_data[g*LANE_W +: LANE_W]),
      .o_par  (w_lane_par[g])
    );
  end

  assign w_odd     = (ODD != 0);
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  // acc already carries the packet's ODD term, so it is folded in on the first beat only.
  assign w_pkt_par = r_acc ^ (^in_data) ^ (r_first & w_odd);
  assign w_err     = in_chk && (w_lane_par != in_par);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_last     <= 1'b0;
      r_out_lane_par <= '0;
      r_out_pkt_par  <= 1'b0;
      r_out_err      <= 1'b0;
      r_acc          <= 1'b0;
      r_first        <= 1'b1;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_out_data     <= in_data;
      r_out_last     <= in_last;
      r_out_lane_par <= w_lane_par;
      r_out_pkt_par  <= w_pkt_par;
      r_out_err      <= w_err;
      r_acc          <= in_last ? 1'b0 : w_pkt_par;
      r_first        <= in_last;
    end else if (out_ready) begin
      r_out_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end else if (w_accept && w_err) begin
      r_err_sticky <= 1'b1;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_last     = r_out_last;
  assign out_lane_par = r_out_lane_par;
  assign out_pkt_par  = r_out_pkt_par;
  assign out_err      = r_out_err;
  assign err_sticky   = r_err_sticky;

`ifdef PARITY_STREAM_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_parity_stream.sv
// Bench for parity_stream: an even (ODD=0) and an odd (ODD=1) instance share one stimulus
// stream and are checked every cycle against a ones-counting packet model.
module tb_parity_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_chk;
  logic [3:0]  in_par;
  logic        out_ready;
  logic        err_clr;

  logic        rdy    [2];
  logic        vld    [2];
  logic [31:0] dat    [2];
  logic        lst    [2];
  logic [3:0]  lpar   [2];
  logic        ppar   [2];
  logic        err    [2];
  logic        sticky [2];
  logic [15:0] cnt    [2];

  int total = 0;
  int bad   = 0;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    parity_stream #(.DATA_W(32), .LANE_W(8), .ODD(k)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (rdy[k]),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_chk       (in_chk),
      .in_par       (in_par),
      .out_valid    (vld[k]),
      .out_ready    (out_ready),
      .out_data     (dat[k]),
      .out_last     (lst[k]),
      .out_lane_par (lpar[k]),
      .out_pkt_par  (ppar[k]),
      .out_err      (err[k]),
      .err_sticky   (sticky[k]),
`ifdef PARITY_STREAM_ERR_CNT_EN
      .err_cnt      (cnt[k]),
`endif
      .err_clr      (err_clr)
    );
`ifndef PARITY_STREAM_ERR_CNT_EN
    assign cnt[k] = 16'h0;
`endif
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: parity is the count of ones in the packet so far, plus one when odd.
  function automatic logic [3:0] lanes_of(input logic [31:0] d, input int odd);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ((($countones(d[i*8 +: 8]) + odd) % 2) == 1);
    return r;
  endfunction

  bit          m_init = 1'b0;
  logic        m_vld;
  logic [31:0] m_data;
  logic        m_last;
  int          m_ones;
  int          m_accepts;
  int          m_delivered;
  logic [3:0]  m_lpar   [2];
  logic        m_ppar   [2];
  logic        m_err    [2];
  logic        m_sticky [2];
  int          m_cnt    [2];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init      <= 1'b1;
      m_vld       <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      m_ones      <= 0;
      m_accepts   <= 0;
      m_delivered <= 0;
      for (int k = 0; k < 2; k++) begin
        m_lpar[k]   <= '0;
        m_ppar[k]   <= 1'b0;
        m_err[k]    <= 1'b0;
        m_sticky[k] <= 1'b0;
        m_cnt[k]    <= 0;
      end
    end else begin
      if (vld[0] && out_ready) m_delivered <= m_delivered + 1;
      if (in_valid && (!m_vld || out_ready)) begin
        m_vld     <= 1'b1;
        m_data    <= in_data;
        m_last    <= in_last;
        m_ones    <= in_last ? 0 : m_ones + $countones(in_data);
        m_accepts <= m_accepts + 1;
        for (int k = 0; k < 2; k++) begin
          m_lpar[k] <= lanes_of(in_data, k);
          m_ppar[k] <= (((m_ones + $countones(in_data) + k) % 2) == 1);
          m_err[k]  <= in_chk && (lanes_of(in_data, k) != in_par);
          if (err_clr) begin
            m_sticky[k] <= 1'b0;
            m_cnt[k]    <= 0;
          end else if (in_chk && (lanes_of(in_data, k) != in_par)) begin
            m_sticky[k] <= 1'b1;
            if (m_cnt[k] < 65535) m_cnt[k] <= m_cnt[k] + 1;
          end
        end
      end else begin
        if (out_ready) m_vld <= 1'b0;
        if (err_clr) begin
          for (int k = 0; k < 2; k++) begin
            m_sticky[k] <= 1'b0;
            m_cnt[k]    <= 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d.in_ready", k), 32'(rdy[k]), 32'(!m_vld || out_ready));
        check($sformatf("u%0d.out_valid", k), 32'(vld[k]), 32'(m_vld));
        check($sformatf("u%0d.out_data", k), dat[k], m_data);
        check($sformatf("u%0d.out_last", k), 32'(lst[k]), 32'(m_last));
        check($sformatf("u%0d.lane_par", k), 32'(lpar[k]), 32'(m_lpar[k]));
        check($sformatf("u%0d.pkt_par", k), 32'(ppar[k]), 32'(m_ppar[k]));
        check($sformatf("u%0d.out_err", k), 32'(err[k]), 32'(m_err[k]));
        check($sformatf("u%0d.err_sticky", k), 32'(sticky[k]), 32'(m_sticky[k]));
`ifdef PARITY_STREAM_ERR_CNT_EN
        check($sformatf("u%0d.err_cnt", k), 32'(cnt[k]), 32'(m_cnt[k]));
`endif
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic l, input logic c, input logic [3:0] p);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_chk   = c;
    in_par   = p;
    @(negedge clk);
    while (!rdy[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL send_timeout data=%0h never accepted within 20 cycles", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_chk   = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] tbl_d [6] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'h8000_0001,
                             32'hFFFF_FFFF, 32'h0102_0408, 32'h7F00_00FE};
  logic        tbl_l [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_chk    = 1'b0;
    in_par    = '0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    idle(3);
    rst_n = 1'b1;
    check("reset.in_ready", 32'(rdy[0]), 32'd1);
    check("reset.out_valid", 32'(vld[0]), 32'd0);

    // Single beat packet
    send(32'h0000_0001, 1'b1, 1'b0, 4'b0000);
    check("single.lane_par_even", 32'(lpar[0]), 32'b0001);
    check("single.pkt_par_even", 32'(ppar[0]), 32'd1);
    check("single.err", 32'(err[0]), 32'd0);
    check("single.lane_par_odd", 32'(lpar[1]), 32'b1110);
    check("single.pkt_par_odd", 32'(ppar[1]), 32'd0);

    // Multi-beat packet
    send(32'h3, 1'b0, 1'b0, 4'b0000);
    check("multi.b0_odd", 32'(ppar[1]), 32'd1);
    check("multi.b0_even", 32'(ppar[0]), 32'd0);
    send(32'h1, 1'b0, 1'b0, 4'b0000);
    check("multi.b1_odd", 32'(ppar[1]), 32'd0);
    check("multi.b1_even", 32'(ppar[0]), 32'd1);
    send(32'h0, 1'b1, 1'b0, 4'b0000);
    check("multi.b2_odd", 32'(ppar[1]), 32'd0);
    check("multi.b2_even", 32'(ppar[0]), 32'd1);
    send(32'h0, 1'b1, 1'b0, 4'b0000);
    check("multi.acc_cleared_odd", 32'(ppar[1]), 32'd1);
    check("multi.acc_cleared_even", 32'(ppar[0]), 32'd0);

    // Check mismatch
    send(32'h0000_0100, 1'b1, 1'b1, 4'b0000);
    check("mismatch.err", 32'(err[0]), 32'd1);
    check("mismatch.lane_par", 32'(lpar[0]), 32'b0010);
    check("mismatch.sticky", 32'(sticky[0]), 32'd1);
`ifdef PARITY_STREAM_ERR_CNT_EN
    check("mismatch.cnt", 32'(cnt[0]), 32'd1);
`endif

    // Clear wins over a simultaneous error
    err_clr = 1'b1;
    send(32'h0000_0100, 1'b1, 1'b1, 4'b0000);
    check("clr_vs_err.sticky", 32'(sticky[0]), 32'd0);
    check("clr_vs_err.cnt", 32'(cnt[0]), 32'd0);
    send(32'h0000_0100, 1'b1, 1'b1, 4'b0010);
    check("match.err_even", 32'(err[0]), 32'd0);
    check("match.err_odd", 32'(err[1]), 32'd1);

    // Backpressure
    idle(1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    in_last   = 1'b0;
    check("bp.first_ready", 32'(rdy[0]), 32'd1);
    idle(1);
    in_data = 32'h22;
    in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp.ready_low", 32'(rdy[0]), 32'd0);
      check("bp.hold_data", dat[0], 32'h11);
      idle(1);
    end
    out_ready = 1'b1;
    idle(1);
    in_valid = 1'b0;
    check("bp.next_beat", dat[0], 32'h22);
    idle(1);
    check("bp.drained", 32'(vld[0]), 32'd0);

    // Directed vectors with downstream bubbles
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) begin
        out_ready = 1'b0;
        idle(1);
        out_ready = 1'b1;
      end
      send(tbl_d[i], tbl_l[i], 1'b1, lanes_of(tbl_d[i], 0));
    end

    // Reset mid-packet
    send(32'h1, 1'b0, 1'b0, 4'b0000);
    send(32'h0, 1'b0, 1'b0, 4'b0000);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("midrst.valid", 32'(vld[0]), 32'd0);
    send(32'h1, 1'b1, 1'b0, 4'b0000);
    check("midrst.pkt_par_even", 32'(ppar[0]), 32'd1);
    check("midrst.pkt_par_odd", 32'(ppar[1]), 32'd0);
    idle(2);
    check("delivered_count", 32'(m_delivered), 32'(m_accepts));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/parity_stream.md
PARITY_STREAM -- requirements
Module: parity_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data beat width in bits; legal values are multiples of LANE_W, 8..256.
REQ-002 SHALL have parameter LANE_W, default 8, meaning bits per parity lane; NL = DATA_W/LANE_W.
REQ-003 SHALL have parameter ODD, default 0, meaning 0 = even parity, 1 = odd parity (the parity bit is inverted).
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk (input, 1) is the sole clock; rst_n (input, 1) is the synchronous active-low reset.
REQ-005 SHALL have the following ports:
- in_valid, input, 1: upstream beat valid.
- in_ready, output, 1: upstream beat accepted when in_valid && in_ready.
- in_data, input, DATA_W: beat data.
- in_last, input, 1: final beat of a packet.
- in_chk, input, 1: 1 = check the beat against in_par; 0 = generate only.
- in_par, input, NL: expected lane parity for the beat.
- out_valid, output, 1: downstream beat valid.
- out_ready, input, 1: downstream accept.
- out_data, output, DATA_W: registered copy of in_data.
- out_last, output, 1: registered copy of in_last.
- out_lane_par, output, NL: per-lane parity of the beat.
- out_pkt_par, output, 1: running packet parity including this beat; final value when out_last = 1.
- out_err, output, 1: lane mismatch on this beat; forced 0 when in_chk = 0.
- err_sticky, output, 1: set by any accepted erroring beat.
- err_clr, input, 1: clears err_sticky and err_cnt.

Function
REQ-006 SHALL compute lane parity bit i as the XOR of in_data[i*LANE_W +: LANE_W], XOR ODD.
REQ-007 SHALL register each accepted beat into a single output stage, so out_valid rises the cycle after acceptance (latency 1).
REQ-008 SHALL drive in_ready = !out_valid || out_ready, combinationally, so back-to-back beats pass at full rate.
REQ-009 SHALL hold all out_* values stable while out_valid && !out_ready.
REQ-010 SHALL keep a packet accumulator acc:
- the accepted beat's out_pkt_par = acc XOR (XOR of the beat's data bits) XOR ODD;
- ODD is applied once per packet, on the first beat only.
REQ-011 SHALL update acc on accept:
- acc <= 0 if in_last;
- otherwise acc <= the raw XOR including this beat.
REQ-012 SHALL treat a single-beat packet (first beat with in_last = 1) as both first and last beat.
REQ-013 SHALL set out_err = in_chk && (computed lane parity != in_par), captured with the beat.
REQ-014 SHALL set err_sticky in the cycle after an erroring beat is accepted.
REQ-015 SHALL give err_clr priority over a simultaneous error set; in that cycle err_sticky stays 0.
REQ-016 SHALL change no state when in_valid = 0, including acc, err_sticky and err_cnt.

Reset
REQ-017 SHALL, while rst_n = 0 at a clk edge, drive the following to 0: out_valid, out_data, out_last, out_lane_par, out_pkt_par, out_err, acc, err_sticky and err_cnt.
REQ-018 SHALL drive in_ready = 1 in the first cycle after reset.
REQ-019 SHALL discard any packet partially transferred when reset asserts mid-packet; the next accepted beat starts a new packet.

Configuration
REQ-020 SHALL, with PARITY_STREAM_ERR_CNT_EN defined:
- add output err_cnt, width 16, counting accepted erroring beats;
- saturate err_cnt at 16'hFFFF;
- clear err_cnt on err_clr, with the same priority as REQ-015.
REQ-021 SHALL, without PARITY_STREAM_ERR_CNT_EN, omit the err_cnt port and counter entirely; all other behaviour is identical.

Structure
REQ-022 SHALL place a shared package parity_pkg holding the following:
- the function lane_parity(data, LANE_W, ODD);
- the constant ERR_CNT_W = 16;
- the localparam derivation of NL.
REQ-023 SHALL instantiate one sub-module parity_lane_xor: combinational, parametrised by LANE_W and ODD, instanced NL times by generate.

Verification
REQ-024 SHALL cover the single beat case:
- stimulus: DATA_W=32, ODD=0, beat 32'h0000_0001, last=1, chk=0;
- response: out_lane_par=4'b0001, out_pkt_par=1, out_err=0, one cycle later.
REQ-025 SHALL cover a multi-beat packet with odd parity:
- stimulus: ODD=1, beats 32'h3, 32'h1, 32'h0 with last on the third;
- response: out_pkt_par = 1,0,0 on the three beats; acc=0 afterwards.
REQ-026 SHALL cover a check mismatch:
- stimulus: chk=1, data 32'h0000_0100, in_par=4'b0000;
- response: out_err=1 with out_lane_par=4'b0010, err_sticky=1 next cycle, err_cnt=1 (macro on).
REQ-027 SHALL cover backpressure:
- stimulus: out_ready=0 for 5 cycles with in_valid=1;
- response: in_ready=0 from the second cycle; outputs stable; no beat lost or duplicated after release.
REQ-028 SHALL cover clear versus error:
- stimulus: err_clr=1 in the same cycle an erroring beat is accepted;
- response: err_sticky=0 and err_cnt=0 the next cycle.
REQ-029 SHALL cover reset mid-packet:
- stimulus: rst_n=0 after beat 2 of 4, then a new packet with beat 32'h1 and last=1;
- response: out_pkt_par=1, with no carry-over from the aborted packet.
